// File: rtl/updown_counter.sv
// updown_counter: parametrised up/down counter with clear, load, wrap/saturate,
// enable prescaler, boundary flags and a registered overflow pulse.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-low reset
//   clr      - synchronous clear (highest priority)
//   load     - synchronous parallel load, clamped to MAX_VAL
//   load_val - value for load
//   en       - count enable (advances the prescaler)
//   dir      - 1 = up, 0 = down
//   count    - registered count value
//   at_zero  - count == 0
//   at_max   - count == MAX_VAL
//   tc       - terminal count for the current direction
//   ovf      - one-cycle pulse on a boundary step (wrap or blocked step)
module updown_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             at_zero,
  output logic             at_max,
  output logic             tc,
  output logic             ovf
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_VAL);
  localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_pre;
  logic             r_ovf;

  logic [WIDTH-1:0] w_count_nxt;
  logic [PW-1:0]    w_pre_nxt;
  logic             w_ovf_nxt;
  logic             w_tick;

  // Flags come straight from the count register; tc tracks dir combinationally.
  assign count   = r_count;
  assign ovf     = r_ovf;
  assign at_zero = (r_count == '0);
  assign at_max  = (r_count == MAXV);
  assign tc      = dir ? at_max : at_zero;
  assign w_tick  = en && (r_pre == PLAST);

  // Next-state: clr > load > step > hold.
  always_comb begin
    w_count_nxt = r_count;
    w_pre_nxt   = r_pre;
    w_ovf_nxt   = 1'b0;
    if (clr) begin
      w_count_nxt = '0;
      w_pre_nxt   = '0;
    end else if (load) begin
      // Widen before comparing so the clamp never wraps.
      w_count_nxt = (32'(load_val) > MAX_VAL) ? MAXV : load_val;
      w_pre_nxt   = '0;
    end else if (en) begin
      if (w_tick) begin
        w_pre_nxt = '0;
        if (tc) begin
          // Boundary step: wrap to the opposite end, or hold when saturating.
          w_ovf_nxt = 1'b1;
          if (SATURATE == 0) begin
            w_count_nxt = dir ? '0 : MAXV;
          end
        end else begin
          w_count_nxt = dir ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
        end
      end else begin
        w_pre_nxt = r_pre + PW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_pre   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_pre   <= w_pre_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: five configurations share one stimulus stream and
// are checked every cycle against a behavioural model, plus directed literals.
module tb_updown_counter;

  localparam int N = 5;
  // Configurations: 0 = W8 defaults, 1 = decade wrap, 2 = decade saturate,
  // 3 = decade prescale 4, 4 = W4 defaults.
  localparam int MAXV [N] = '{255, 9, 9, 9, 15};
  localparam int SATV [N] = '{0, 0, 1, 0, 0};
  localparam int PREV [N] = '{1, 1, 1, 4, 1};
  localparam int WID  [N] = '{8, 4, 4, 4, 4};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       en = 1'b0;
  logic       dir = 1'b1;

  logic [7:0] c0;
  logic [3:0] c1, c2, c3, c4;
  logic [N-1:0] a_z, a_m, a_tc, a_ovf;
  int a_cnt [N];

  int checks = 0;
  int errors = 0;

  int m_cnt [N];
  int m_pre [N];
  int m_ovf [N];

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(8)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .count(c0), .at_zero(a_z[0]), .at_max(a_m[0]),
    .tc(a_tc[0]), .ovf(a_ovf[0]));
  updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val[3:0]),
    .en(en), .dir(dir), .count(c1), .at_zero(a_z[1]), .at_max(a_m[1]),
    .tc(a_tc[1]), .ovf(a_ovf[1]));
  updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val[3:0]),
    .en(en), .dir(dir), .count(c2), .at_zero(a_z[2]), .at_max(a_m[2]),
    .tc(a_tc[2]), .ovf(a_ovf[2]));
  updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(4)) u3 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val[3:0]),
    .en(en), .dir(dir), .count(c3), .at_zero(a_z[3]), .at_max(a_m[3]),
    .tc(a_tc[3]), .ovf(a_ovf[3]));
  updown_counter #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val[3:0]),
    .en(en), .dir(dir), .count(c4), .at_zero(a_z[4]), .at_max(a_m[4]),
    .tc(a_tc[4]), .ovf(a_ovf[4]));

  assign a_cnt[0] = int'(c0);
  assign a_cnt[1] = int'(c1);
  assign a_cnt[2] = int'(c2);
  assign a_cnt[3] = int'(c3);
  assign a_cnt[4] = int'(c4);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: plain arithmetic from the counting rules.
  always @(posedge clk or negedge rst) begin : model
    int lv;
    int nc;
    int np;
    int no;
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        nc = 0; np = 0; no = 0;
      end else begin
        nc = m_cnt[i]; np = m_pre[i]; no = 0;
        lv = int'(load_val) % (1 << WID[i]);
        if (clr) begin
          nc = 0; np = 0;
        end else if (load) begin
          nc = (lv > MAXV[i]) ? MAXV[i] : lv;
          np = 0;
        end else if (en) begin
          np = m_pre[i] + 1;
          if (np == PREV[i]) begin
            np = 0;
            if (dir && m_cnt[i] == MAXV[i]) begin
              no = 1;
              nc = SATV[i] != 0 ? MAXV[i] : 0;
            end else if (!dir && m_cnt[i] == 0) begin
              no = 1;
              nc = SATV[i] != 0 ? 0 : MAXV[i];
            end else begin
              nc = dir ? m_cnt[i] + 1 : m_cnt[i] - 1;
            end
          end
        end
      end
      m_cnt[i] <= nc;
      m_pre[i] <= np;
      m_ovf[i] <= no;
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (rst || $time > 0) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("u%0d.count", i), a_cnt[i], m_cnt[i]);
        chk($sformatf("u%0d.at_zero", i), int'(a_z[i]), int'(m_cnt[i] == 0));
        chk($sformatf("u%0d.at_max", i), int'(a_m[i]), int'(m_cnt[i] == MAXV[i]));
        chk($sformatf("u%0d.tc", i), int'(a_tc[i]),
            int'(dir ? (m_cnt[i] == MAXV[i]) : (m_cnt[i] == 0)));
        chk($sformatf("u%0d.ovf", i), int'(a_ovf[i]), m_ovf[i]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int nov;

  initial begin
    #2 rst = 1'b0;
    step(2);
    chk("reset_count", int'(c0), 0);
    chk("reset_at_zero", int'(a_z[0]), 1);
    rst = 1'b1;

    // Mid-count asynchronous reset.
    load = 1'b1; load_val = 8'h37;
    step(1);
    load = 1'b0;
    chk("load_37", int'(c0), 8'h37);
    en = 1'b1; dir = 1'b1;
    step(2);
    chk("count_39", int'(c0), 8'h39);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_count", int'(c0), 0);
    chk("async_rst_at_zero", int'(a_z[0]), 1);
    chk("async_rst_at_max", int'(a_m[0]), 0);
    step(1);
    rst = 1'b1;
    step(5);
    chk("count5", int'(c0), 5);
    chk("pre4_after5", int'(c3), 1);
    en = 1'b0;

    // Decade wrap up and down.
    load = 1'b1; load_val = 8'd8;
    step(1);
    load = 1'b0; en = 1'b1; dir = 1'b1;
    step(1);
    chk("dec_9", int'(c1), 9);
    chk("dec_9_tc", int'(a_tc[1]), 1);
    step(1);
    chk("dec_wrap0", int'(c1), 0);
    chk("dec_wrap_ovf", int'(a_ovf[1]), 1);
    step(1);
    chk("dec_1", int'(c1), 1);
    chk("dec_1_ovf", int'(a_ovf[1]), 0);
    en = 1'b0; load = 1'b1; load_val = 8'd0;
    step(1);
    load = 1'b0; en = 1'b1; dir = 1'b0;
    step(1);
    chk("dec_down9", int'(c1), 9);
    chk("dec_down_ovf", int'(a_ovf[1]), 1);
    en = 1'b0;

    // Saturation at MAX_VAL.
    load = 1'b1; load_val = 8'd9;
    step(1);
    load = 1'b0; en = 1'b1; dir = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("sat_hold", int'(c2), 9);
      chk("sat_ovf", int'(a_ovf[2]), 1);
    end
    dir = 1'b0;
    step(1);
    chk("sat_down8", int'(c2), 8);
    chk("sat_down_ovf", int'(a_ovf[2]), 0);
    en = 1'b0;

    // Prescaler continuous and gapped.
    clr = 1'b1;
    step(1);
    clr = 1'b0; en = 1'b1; dir = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk("pre_cont", int'(c3), (k == 4) ? 1 : 0);
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(2);
    en = 1'b0;
    step(3);
    en = 1'b1;
    step(1);
    chk("pre_gap_a", int'(c3), 0);
    step(1);
    chk("pre_gap_b", int'(c3), 1);
    en = 1'b0;

    // Load clamp, clear over load, load restarting the prescaler.
    load = 1'b1; load_val = 8'd12;
    step(1);
    chk("clamp_u1", int'(c1), 9);
    chk("clamp_u2", int'(c2), 9);
    chk("clamp_u3", int'(c3), 9);
    clr = 1'b1;
    step(1);
    chk("clr_over_load", int'(c1), 0);
    clr = 1'b0; load = 1'b0; en = 1'b1; dir = 1'b1;
    step(2);
    load = 1'b1; load_val = 8'd3;
    step(1);
    chk("load_en", int'(c3), 3);
    load = 1'b0;
    step(3);
    chk("load_pre_hold", int'(c3), 3);
    step(1);
    chk("load_pre_step", int'(c3), 4);
    en = 1'b0;

    // Full-range wrap on a 4-bit counter.
    clr = 1'b1;
    step(1);
    clr = 1'b0; en = 1'b1; dir = 1'b1;
    nov = 0;
    for (int k = 0; k < 17; k++) begin
      step(1);
      if (a_ovf[4]) nov++;
    end
    chk("full_end", int'(c4), 1);
    chk("full_ovf_pulses", nov, 1);
    en = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
